datapoint_buffer_arbiter: RTL

//  Single owner of the single-port datapoint buffer memory (wrEna/Addr/dataIn/rdData, sync read).

---
 rtl/datapoint_buffer_arbiter.sv | 112 +++++++++++
 1 files changed

// File: rtl/datapoint_buffer_arbiter.sv
// Arbitrates the single-port datapoint buffer between host writes and a read-burst streamer.
// Optional: define DPBUF_WR_INTERLEAVE_EN to accept host writes while a beat is held.
module datapoint_buffer_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16,
  parameter int LEN_W  = ADDR_W + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_wrValid,
  input  logic [ADDR_W-1:0] io_wrAddr,
  input  logic [DATA_W-1:0] io_wrData,
  output logic              io_wrReady,
  input  logic              io_rdStart,
  input  logic [ADDR_W-1:0] io_rdBase,
  input  logic [LEN_W-1:0]  io_rdLen,
  output logic              io_rdValid,
  output logic [DATA_W-1:0] io_rdData,
  input  logic              io_rdReady,
  output logic              io_rdBusy,
  output logic              io_rdDone,
  output logic              io_memWrEna,
  output logic [ADDR_W-1:0] io_memAddr,
  output logic [DATA_W-1:0] io_memDataIn,
  input  logic [DATA_W-1:0] io_memRdData
);

  typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_CAP, RD_HOLD, DONE} state_t;

  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_base;
  logic [LEN_W-1:0]  r_len, r_cnt, w_cntInc;
  logic [DATA_W-1:0] r_rdData;
  logic              r_rdValid;
  logic              w_wrReady, w_wrAcc, w_rdAcc;
  logic [ADDR_W-1:0] w_rdAddr;

  assign w_cntInc = r_cnt + 1'b1;
  assign w_rdAddr = r_base + r_cnt[ADDR_W-1:0];
  assign w_rdAcc  = r_rdValid && io_rdReady;

  always_comb begin
    w_next    = r_state;
    w_wrReady = 1'b0;
    case (r_state)
      IDLE: begin
        w_wrReady = !io_rdStart;
        if (io_rdStart) w_next = (io_rdLen == '0) ? DONE : RD_ISSUE;
      end
      RD_ISSUE: w_next = RD_CAP;
      RD_CAP:   w_next = RD_HOLD;
      RD_HOLD: begin
`ifdef DPBUF_WR_INTERLEAVE_EN
        w_wrReady = 1'b1;
`endif
        if (w_rdAcc) w_next = (w_cntInc == r_len) ? DONE : RD_ISSUE;
      end
      DONE:     w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  // Combinational outputs are gated by reset so everything reads 0 while reset is held.
  always_comb begin
    w_wrAcc      = reset && io_wrValid && w_wrReady;
    io_wrReady   = reset && w_wrReady;
    io_memWrEna  = w_wrAcc;
    io_memAddr   = '0;
    io_memDataIn = '0;
    if (w_wrAcc) begin
      io_memAddr   = io_wrAddr;
      io_memDataIn = io_wrData;
    end else if (reset && r_state == RD_ISSUE) begin
      io_memAddr = w_rdAddr;
    end
  end

  assign io_rdBusy  = (r_state != IDLE);
  assign io_rdDone  = (r_state == DONE);
  assign io_rdValid = r_rdValid;
  assign io_rdData  = r_rdData;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_base    <= '0;
      r_len     <= '0;
      r_cnt     <= '0;
      r_rdData  <= '0;
      r_rdValid <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: if (io_rdStart && io_rdLen != '0) begin
          r_base <= io_rdBase;
          r_len  <= io_rdLen;
          r_cnt  <= '0;
        end
        RD_CAP: begin
          r_rdData  <= io_memRdData;
          r_rdValid <= 1'b1;
        end
        RD_HOLD: if (w_rdAcc) begin
          r_cnt     <= w_cntInc;
          r_rdValid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
